// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_stage
//  Purpose  : Instruction fetch and IF/ID pipeline register. Owns the PC,
//             the jsb/ret return-address stack, redirect bubbles, stall
//             hold and halt detection.
//  Revision : 1.0 - initial release
// ============================================================================
module fetch_stage #(
  parameter int               ADDR_W      = 12,
  parameter int               INSTR_W     = 19,
  parameter int               STACK_DEPTH = 8,
  parameter logic [INSTR_W-1:0] NOP_WORD  = 19'h48000,
  parameter logic [INSTR_W-1:0] HALT_WORD = 19'h7FFFF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall,
  input  logic [1:0]         pc_src,
  input  logic [ADDR_W-1:0]  jump_addr,
  input  logic [ADDR_W-1:0]  branch_addr,
  input  logic               stack_push,
  input  logic               stack_pop,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_data,
  output logic [INSTR_W-1:0] if_id_instr,
  output logic [ADDR_W-1:0]  if_id_pc_next,
  output logic               if_id_valid,
  output logic               is_halt,
  output logic               stack_overflow,
  output logic               stack_underflow
);

  // Stack pointer counts valid entries, so it needs one more value than
  // there are entries; the entry index only spans the entries themselves.
  localparam int c_sp_w  = $clog2(STACK_DEPTH + 1);
  localparam int c_idx_w = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  localparam logic [1:0] c_SRC_SEQ    = 2'b00;
  localparam logic [1:0] c_SRC_JUMP   = 2'b01;
  localparam logic [1:0] c_SRC_RET    = 2'b10;
  localparam logic [1:0] c_SRC_BRANCH = 2'b11;

  localparam logic [c_sp_w-1:0] c_SP_FULL = c_sp_w'(STACK_DEPTH);
  localparam logic [c_sp_w-1:0] c_SP_ONE  = c_sp_w'(1);

  // Architectural state
  logic [ADDR_W-1:0]  r_pc;
  logic [c_sp_w-1:0]  r_sp;
  logic [ADDR_W-1:0]  r_stack [STACK_DEPTH];
  logic [INSTR_W-1:0] r_instr;
  logic [ADDR_W-1:0]  r_pc_next;
  logic               r_valid;
  logic               r_ovf;
  logic               r_unf;

  // Combinational next-state
  logic               w_halt;
  logic               w_adv;
  logic               w_push;
  logic               w_pop;
  logic [ADDR_W-1:0]  w_pc_inc;
  logic [c_sp_w-1:0]  w_sp_m1;
  logic               w_sp_empty;
  logic               w_sp_full;
  logic [ADDR_W-1:0]  w_top;
  logic [ADDR_W-1:0]  w_pc_nxt;
  logic [c_sp_w-1:0]  w_sp_nxt;
  logic               w_wr_en;
  logic [c_idx_w-1:0] w_wr_idx;
  logic               w_set_ovf;
  logic               w_set_unf;

  assign imem_addr       = r_pc;
  assign if_id_instr     = r_instr;
  assign if_id_pc_next   = r_pc_next;
  assign if_id_valid     = r_valid;
  assign stack_overflow  = r_ovf;
  assign stack_underflow = r_unf;

  // A squashed halt word carries valid = 0, so it can never raise halt.
  assign w_halt  = r_valid && (r_instr == HALT_WORD);
  assign is_halt = w_halt;

  // The stage only moves when neither stalled nor halted; redirect and
  // stack requests are masked otherwise so they re-present cleanly later.
  assign w_adv  = !stall && !w_halt;
  assign w_push = w_adv && stack_push;
  assign w_pop  = w_adv && stack_pop;

  assign w_pc_inc   = r_pc + ADDR_W'(1);
  assign w_sp_m1    = r_sp - c_SP_ONE;
  assign w_sp_empty = (r_sp == '0);
  assign w_sp_full  = (r_sp == c_SP_FULL);

  // Return target: top entry, or zero when the stack is empty.
  assign w_top = w_sp_empty ? '0 : r_stack[w_sp_m1[c_idx_w-1:0]];

  // Stack pointer, write port and sticky flag updates.
  always_comb begin
    w_sp_nxt  = r_sp;
    w_wr_en   = 1'b0;
    w_wr_idx  = r_sp[c_idx_w-1:0];
    w_set_ovf = 1'b0;
    w_set_unf = 1'b0;
    if (w_push && w_pop && !w_sp_empty) begin
      // Combined push/pop replaces the top entry in place.
      w_wr_en  = 1'b1;
      w_wr_idx = w_sp_m1[c_idx_w-1:0];
    end else if (w_push) begin
      // Covers a lone push and push+pop on an empty stack.
      if (w_sp_full) begin
        w_set_ovf = 1'b1;
      end else begin
        w_wr_en  = 1'b1;
        w_wr_idx = r_sp[c_idx_w-1:0];
        w_sp_nxt = r_sp + c_SP_ONE;
      end
    end else if (w_pop) begin
      if (w_sp_empty) begin
        w_set_unf = 1'b1;
      end else begin
        w_sp_nxt = w_sp_m1;
      end
    end
  end

  // PC source selection; the ret target is read before any same-cycle write.
  always_comb begin
    w_pc_nxt = w_pc_inc;
    case (pc_src)
      c_SRC_SEQ:    w_pc_nxt = w_pc_inc;
      c_SRC_JUMP:   w_pc_nxt = jump_addr;
      c_SRC_RET:    w_pc_nxt = w_top;
      c_SRC_BRANCH: w_pc_nxt = branch_addr;
      default:      w_pc_nxt = w_pc_inc;
    endcase
  end

  // PC, IF/ID register, stack pointer and sticky flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc      <= '0;
      r_sp      <= '0;
      r_instr   <= NOP_WORD;
      r_pc_next <= '0;
      r_valid   <= 1'b0;
      r_ovf     <= 1'b0;
      r_unf     <= 1'b0;
    end else if (w_adv) begin
      r_pc <= w_pc_nxt;
      r_sp <= w_sp_nxt;
      if (pc_src == c_SRC_SEQ) begin
        r_instr   <= imem_data;
        r_pc_next <= w_pc_inc;
        r_valid   <= 1'b1;
      end else begin
        // Wrong-path fetch is replaced by a single bubble.
        r_instr   <= NOP_WORD;
        r_pc_next <= '0;
        r_valid   <= 1'b0;
      end
      if (w_set_ovf) r_ovf <= 1'b1;
      if (w_set_unf) r_unf <= 1'b1;
    end
  end

  // Return-address storage; contents are don't-care after reset.
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_stack[w_wr_idx] <= r_pc_next;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fetch_stage
//  Purpose  : Directed self-checking bench for fetch_stage.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_stage;

  localparam logic [18:0] c_NOP  = 19'h48000;
  localparam logic [18:0] c_HALT = 19'h7FFFF;

  logic        clk;
  logic        rst;
  logic        stall;
  logic [1:0]  pc_src;
  logic [11:0] jump_addr;
  logic [11:0] branch_addr;
  logic        stack_push;
  logic        stack_pop;
  logic [11:0] imem_addr;
  logic [18:0] imem_data;
  logic [18:0] if_id_instr;
  logic [11:0] if_id_pc_next;
  logic        if_id_valid;
  logic        is_halt;
  logic        stack_overflow;
  logic        stack_underflow;

  logic [18:0] mem [0:4095];

  int n_total;
  int n_bad;

  fetch_stage dut (
    .clk             (clk),
    .rst             (rst),
    .stall           (stall),
    .pc_src          (pc_src),
    .jump_addr       (jump_addr),
    .branch_addr     (branch_addr),
    .stack_push      (stack_push),
    .stack_pop       (stack_pop),
    .imem_addr       (imem_addr),
    .imem_data       (imem_data),
    .if_id_instr     (if_id_instr),
    .if_id_pc_next   (if_id_pc_next),
    .if_id_valid     (if_id_valid),
    .is_halt         (is_halt),
    .stack_overflow  (stack_overflow),
    .stack_underflow (stack_underflow)
  );

  assign imem_data = mem[imem_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_state(input string tag);
    check_value({tag, "_addr"},  32'(imem_addr), 32'h0);
    check_value({tag, "_instr"}, 32'(if_id_instr), 32'(c_NOP));
    check_value({tag, "_pcn"},   32'(if_id_pc_next), 32'h0);
    check_value({tag, "_valid"}, 32'(if_id_valid), 32'h0);
    check_value({tag, "_halt"},  32'(is_halt), 32'h0);
    check_value({tag, "_ovf"},   32'(stack_overflow), 32'h0);
    check_value({tag, "_unf"},   32'(stack_underflow), 32'h0);
  endtask

  initial begin
    n_total     = 0;
    n_bad       = 0;
    rst         = 1'b1;
    stall       = 1'b0;
    pc_src      = 2'b00;
    jump_addr   = '0;
    branch_addr = '0;
    stack_push  = 1'b0;
    stack_pop   = 1'b0;
    for (int i = 0; i < 4096; i++) mem[i] = 19'(i);

    // Reset state, then free-running fetch from address 0
    repeat (2) @(posedge clk);
    #1;
    check_reset_state("rst");
    rst = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      tick();
      check_value("seq_addr",  32'(imem_addr), 32'(k));
      check_value("seq_instr", 32'(if_id_instr), 32'(k - 1));
      check_value("seq_valid", 32'(if_id_valid), 32'h1);
      check_value("seq_pcn",   32'(if_id_pc_next), 32'(k));
    end
    tick();
    tick();
    check_value("pc5", 32'(imem_addr), 32'h5);

    // Jump: one bubble, then target word
    pc_src = 2'b01; jump_addr = 12'h0A0;
    tick();
    pc_src = 2'b00;
    check_value("jmp_addr",  32'(imem_addr), 32'h0A0);
    check_value("jmp_bub",   32'(if_id_instr), 32'(c_NOP));
    check_value("jmp_valid", 32'(if_id_valid), 32'h0);
    check_value("jmp_pcn0",  32'(if_id_pc_next), 32'h0);
    tick();
    check_value("jmp_instr", 32'(if_id_instr), 32'h0A0);
    check_value("jmp_v1",    32'(if_id_valid), 32'h1);
    check_value("jmp_pcn",   32'(if_id_pc_next), 32'h0A1);

    // jsb / ret round trip
    pc_src = 2'b01; jump_addr = 12'h010;
    tick();
    pc_src = 2'b00;
    tick();
    check_value("jsb_pcn", 32'(if_id_pc_next), 32'h011);
    stack_push = 1'b1; pc_src = 2'b01; jump_addr = 12'h200;
    tick();
    stack_push = 1'b0; pc_src = 2'b00;
    check_value("jsb_addr", 32'(imem_addr), 32'h200);
    check_value("jsb_sp",   32'(dut.r_sp), 32'h1);
    repeat (5) tick();
    check_value("ret_from", 32'(imem_addr), 32'h205);
    stack_pop = 1'b1; pc_src = 2'b10;
    tick();
    stack_pop = 1'b0; pc_src = 2'b00;
    check_value("ret_addr", 32'(imem_addr), 32'h011);
    check_value("ret_sp",   32'(dut.r_sp), 32'h0);
    check_value("ret_ovf",  32'(stack_overflow), 32'h0);
    check_value("ret_unf",  32'(stack_underflow), 32'h0);

    // Nine pushes of 0x012..0x01A; the ninth overflows
    tick();
    check_value("push_pcn", 32'(if_id_pc_next), 32'h012);
    stack_push = 1'b1;
    for (int k = 0; k < 9; k++) begin
      tick();
      if (k == 7) check_value("ovf_early", 32'(stack_overflow), 32'h0);
    end
    stack_push = 1'b0;
    check_value("ovf_set", 32'(stack_overflow), 32'h1);
    check_value("ovf_sp",  32'(dut.r_sp), 32'h8);

    // Nine pops: LIFO order 0x019..0x012, then 0 with underflow
    stack_pop = 1'b1; pc_src = 2'b10;
    for (int k = 0; k < 9; k++) begin
      tick();
      check_value("pop_tgt", 32'(imem_addr), (k < 8) ? 32'(12'h019 - k) : 32'h0);
      if (k == 7) check_value("unf_early", 32'(stack_underflow), 32'h0);
    end
    stack_pop = 1'b0; pc_src = 2'b00;
    check_value("unf_set", 32'(stack_underflow), 32'h1);
    check_value("unf_sp",  32'(dut.r_sp), 32'h0);

    // Stall masks branch and push, then branch on release
    tick();
    tick();
    check_value("pre_stall", 32'(imem_addr), 32'h2);
    stall = 1'b1; pc_src = 2'b11; branch_addr = 12'h333; stack_push = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check_value("stl_addr",  32'(imem_addr), 32'h2);
      check_value("stl_instr", 32'(if_id_instr), 32'h1);
      check_value("stl_pcn",   32'(if_id_pc_next), 32'h2);
      check_value("stl_sp",    32'(dut.r_sp), 32'h0);
    end
    stall = 1'b0; stack_push = 1'b0;
    tick();
    pc_src = 2'b00;
    check_value("br_addr",  32'(imem_addr), 32'h333);
    check_value("br_valid", 32'(if_id_valid), 32'h0);

    // Halt word at address 4 freezes the stage
    mem[4] = c_HALT;
    pc_src = 2'b01; jump_addr = 12'h004;
    tick();
    pc_src = 2'b00;
    check_value("hlt_pre", 32'(is_halt), 32'h0);
    tick();
    check_value("hlt_set",   32'(is_halt), 32'h1);
    check_value("hlt_instr", 32'(if_id_instr), 32'(c_HALT));
    check_value("hlt_addr",  32'(imem_addr), 32'h5);
    pc_src = 2'b01; jump_addr = 12'h100; stack_push = 1'b1;
    for (int k = 0; k < 10; k++) begin
      stall = k[0];
      tick();
      check_value("hlt_hold", 32'(imem_addr), 32'h5);
      check_value("hlt_stay", 32'(is_halt), 32'h1);
    end
    stall = 1'b0; stack_push = 1'b0;

    // Asynchronous reset in the middle of halt
    rst = 1'b1;
    #1;
    check_reset_state("arst");
    mem[4] = 19'h00004;

    // Halt word on a squashed fetch never raises halt
    mem[0] = c_HALT;
    pc_src = 2'b01; jump_addr = 12'h050;
    @(negedge clk);
    rst = 1'b0;
    tick();
    pc_src = 2'b00;
    check_value("sq_halt",  32'(is_halt), 32'h0);
    check_value("sq_addr",  32'(imem_addr), 32'h050);
    check_value("sq_valid", 32'(if_id_valid), 32'h0);
    tick();
    check_value("sq_halt2", 32'(is_halt), 32'h0);
    check_value("sq_instr", 32'(if_id_instr), 32'h050);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
Instruction-fetch stage and IF/ID pipeline register for the 19-bit-instruction pipeline. It sits directly upstream of the decode controller: it drives instruction memory, latches the fetched word for decode, and consumes the controller's pc_src, stack_push and stack_pop outputs. It owns the PC, the hardware return-address stack for jsb/ret, bubble insertion on redirect, stall hold, and halt detection.

Parameters:
ADDR_W, 12, instruction-address width (PC, jump/branch targets, stack entries)
INSTR_W, 19, instruction width
STACK_DEPTH, 8, return-address stack entries (power of two)
NOP_WORD, 19'h48000, bubble encoding (memory class, sub-op 2'b10: no read, no write, no reg write, no flag update)
HALT_WORD, 19'h7FFFF, halt encoding

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-high
stall  in  1  hazard hold; freezes the stage and masks redirect/stack inputs
pc_src  in  2  00 = PC+1, 01 = jump, 10 = ret (stack pop), 11 = branch
jump_addr  in  ADDR_W  jump target; decode supplies if_id_instr[11:0]
branch_addr  in  ADDR_W  taken-branch target, computed by decode
stack_push  in  1  push return address (jsb)
stack_pop  in  1  pop return address (ret)
imem_addr  out  ADDR_W  instruction-memory address; always equals the PC
imem_data  in  INSTR_W  instruction word; combinational read of imem_addr
if_id_instr  out  INSTR_W  instruction presented to decode
if_id_pc_next  out  ADDR_W  address following if_id_instr
if_id_valid  out  1  0 when if_id_instr is a bubble
is_halt  out  1  high while the halt word is in IF/ID; sticky
stack_overflow  out  1  sticky: push attempted while full
stack_underflow  out  1  sticky: pop attempted while empty

Behaviour:
- Reset (async, any time, including mid-redirect or mid-halt) sets:
  - pc = 0, sp = 0, stack contents don't-care
  - if_id_instr = NOP_WORD, if_id_pc_next = 0, if_id_valid = 0
  - is_halt = 0, both stack flags = 0
  - The first fetch after reset release comes from address 0.
- imem_addr = pc, combinationally. The instruction appears at if_id_instr 1 cycle after its address is on imem_addr.
- Normal edge (stall = 0, is_halt = 0, pc_src = 00):
  - pc <= pc+1, wrapping 0xFFF -> 0x000
  - if_id_instr <= imem_data, if_id_pc_next <= pc+1, if_id_valid <= 1
- Redirect edge (pc_src != 00; stall = 0, is_halt = 0):
  - pc <= jump_addr (01), stack top (10), or branch_addr (11)
  - IF/ID is loaded with NOP_WORD, valid = 0, pc_next = 0; the wrong-path fetch is squashed.
  - Redirect penalty is exactly 1 bubble.
- Stack: array of STACK_DEPTH entries, sp = number of valid entries (0..STACK_DEPTH).
  - Push: writes current if_id_pc_next (address after the jsb) to entry sp, then sp+1.
  - Pop: supplies entry sp-1 as the ret target, then sp-1.
  - Push while sp = STACK_DEPTH: push dropped, stack_overflow set; the jump still happens.
  - Pop while sp = 0: target = 0, sp stays 0, stack_underflow set.
  - Push and pop in the same cycle: entry sp-1 is overwritten with the return address, sp unchanged, pc follows pc_src. If sp = 0, this is treated as a push only.
- Stall (stall = 1, is_halt = 0):
  - pc, IF/ID, sp and stack contents all hold.
  - pc_src, stack_push and stack_pop are ignored; the stalled decode instruction re-presents them on the unstalled cycle.
- Halt:
  - is_halt is combinationally 1 when if_id_instr == HALT_WORD and if_id_valid = 1.
  - Once is_halt is 1, every register holds (the halt word stays in IF/ID), all inputs are ignored, and only rst clears it.
  - A halt word that arrives as a squashed (bubbled) fetch never asserts is_halt.
- Stack flags are sticky until reset and have no effect on fetch other than the behaviour defined above.

Test Plan:
- Reset then 4 free-running cycles, imem[i] = 19'h00000+i: imem_addr goes 0, 1, 2, 3; if_id_instr = imem[0..2] in cycles 1..3; valid = 1 from cycle 1; if_id_pc_next = 1, 2, 3.
- With pc = 5, assert pc_src = 01, jump_addr = 12'h0A0 for one cycle: next imem_addr = 0x0A0; IF/ID = 19'h48000 with valid = 0 for 1 cycle; the following cycle shows imem[0x0A0] with pc_next = 0x0A1.
- jsb at pc_next = 0x011 (push + pc_src 01 to 0x200), then ret at 0x205 (pop + pc_src 10): fetch resumes at 0x011; sp returns to 0; no flags set.
- Nine consecutive pushes: the ninth is dropped and stack_overflow = 1. Then 9 pops: the first 8 targets are returned in LIFO order, the ninth targets 0 and stack_underflow = 1.
- Hold stall = 1 for 3 cycles with pc_src = 11, branch_addr = 0x333: pc and IF/ID unchanged throughout, no redirect. On release with pc_src = 11, pc = 0x333.
- Place HALT_WORD at imem[4]: is_halt = 1 the cycle it reaches IF/ID and pc stays 5 for 10 cycles. Place HALT_WORD at the fetch squashed by a jump: is_halt stays 0. Assert rst mid-halt: all outputs return to their reset values.
